uart_phy: RTL and testbench

- Serial line engine directly upstream of the buffered Wishbone UART.
- Deserialises the RX pin into byte strobes (o_rx_data/o_rx_stb), which feed that block's i_rx_data/i_rx_stb.
- Serialises bytes handed over on i_tx_data/i_tx_stb, reporting o_tx_busy back to it.
- Frame format fixed at 8N1, LSB first.

---
 rtl/uart_phy.sv | 149 ++++++++++++++
 tb/tb_uart_phy.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_phy.sv
// uart_phy: 8N1 LSB-first serial line engine, RX deserialiser and TX serialiser sharing one clock
module uart_phy #(
  parameter int MASTER_CLOCK_FREQ = 50_000_000,
  parameter int BAUD              = 115200
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_stb,
  output logic       o_rx_frame_err,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_stb,
  output logic       o_tx_busy
);
  localparam int CLKS_PER_BIT = MASTER_CLOCK_FREQ / BAUD;
  localparam int TW = CLKS_PER_BIT < 4 ? 2 : $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_phy: MASTER_CLOCK_FREQ / BAUD must be at least 4");
  end
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  rx_state_t rx_state_q, rx_state_d;
  logic [1:0] rx_sync_q, rx_sync_d;
  logic [TW-1:0] rx_tmr_q, rx_tmr_d;
  logic [2:0] rx_idx_q, rx_idx_d;
  logic [7:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic rx_stb_q, rx_stb_d, rx_ferr_q, rx_ferr_d;
  logic rx_s, rx_tick, rx_stop_tick;
  tx_state_t tx_state_q, tx_state_d;
  logic [TW-1:0] tx_tmr_q, tx_tmr_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic tx_q, tx_d, busy_q, busy_d, tx_tick;
  assign rx_s = rx_sync_q[1];
  assign rx_tick = rx_tmr_q == '0;
  assign tx_tick = tx_tmr_q == '0;
  assign o_rx_data = rx_data_q;
  assign o_rx_stb = rx_stb_q;
  assign o_rx_frame_err = rx_ferr_q;
  assign o_uart_tx = tx_q;
  assign o_tx_busy = busy_q;
  // synchroniser resets to the idle level so reset release never looks like a start bit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_tmr_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_stb_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_tmr_q   <= rx_tmr_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_stb_q   <= rx_stb_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], i_uart_rx};
    rx_state_d = rx_state_q;
    rx_tmr_d   = rx_tick ? rx_tmr_q : rx_tmr_q - TW'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      RX_IDLE: if (!rx_s) begin
        rx_state_d = RX_START;
        rx_tmr_d   = HALF_LAST;
      end
      RX_START: if (rx_tick) begin
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        rx_tmr_d   = BIT_LAST;
        rx_idx_d   = '0;
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_d = {rx_s, rx_shift_q[7:1]};
        rx_tmr_d   = BIT_LAST;
        rx_idx_d   = rx_idx_q + 3'd1;
        rx_state_d = rx_idx_q == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (rx_tick) rx_state_d = rx_s ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end
  always_comb begin
    rx_stop_tick = rx_state_q == RX_STOP && rx_tick;
    rx_stb_d     = rx_stop_tick && rx_s;
    rx_ferr_d    = rx_stop_tick && !rx_s;
    rx_data_d    = rx_stb_d ? rx_shift_q : rx_data_q;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_tmr_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tmr_q   <= tx_tmr_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tick ? BIT_LAST : tx_tmr_q - TW'(1);
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_tmr_d = BIT_LAST;
        if (i_tx_stb) begin
          tx_state_d = TX_START;
          tx_shift_d = i_tx_data;
        end
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
      end
      TX_DATA: if (tx_tick) begin
        tx_state_d = tx_idx_q == 3'd7 ? TX_STOP : TX_DATA;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_idx_d   = tx_idx_q + 3'd1;
      end
      TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end
  // line level is decided from the next state so the pin changes on the same edge as the FSM
  always_comb begin
    tx_d   = tx_state_d == TX_START ? 1'b0 : tx_state_d == TX_DATA ? tx_shift_d[0] : 1'b1;
    busy_d = tx_state_d != TX_IDLE;
  end
endmodule

// File: tb/tb_uart_phy.sv
// tb_uart_phy: directed stimulus with a frame-level line model checked every cycle, plus literal checks
module tb_uart_phy;
  logic i_clk = 1'b0, i_reset_n = 1'b0, rx_drv = 1'b1, loop_en = 1'b0, i_tx_stb = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic i_uart_rx, o_uart_tx, o_rx_stb, o_rx_frame_err, o_tx_busy;
  logic [7:0] o_rx_data;
  int checks = 0, failures = 0;
  int stb_cnt = 0, err_cnt = 0;
  logic [7:0] rx_q[$];
  logic cap_line, cap_stb;
  logic [7:0] cap_data;
  bit tm_active;
  int tm_pos;
  logic [9:0] tm_frame;
  int rm_mode, rm_s, rm_k, n;
  logic [7:0] rm_bits;
  logic [9:0] ev, ev_d1, ev_d2;
  logic e_stb, e_err, exp_tx;
  logic [7:0] e_data;
  logic [9:0] a5_line = 10'b1101001010;

  assign i_uart_rx = loop_en ? o_uart_tx : rx_drv;
  always #5 i_clk = ~i_clk;

  uart_phy #(.MASTER_CLOCK_FREQ(800), .BAUD(100)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx),
    .o_rx_data(o_rx_data), .o_rx_stb(o_rx_stb), .o_rx_frame_err(o_rx_frame_err),
    .i_tx_data(i_tx_data), .i_tx_stb(i_tx_stb), .o_tx_busy(o_tx_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: TX frames as 10-bit words, RX as a mid-bit line decoder whose results show up
  // two edges later (input synchroniser) in registered outputs.
  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      cap_line = i_uart_rx;
      cap_stb  = i_tx_stb;
      cap_data = i_tx_data;
      @(posedge i_clk);
      if (!i_reset_n) begin
        tm_active = 0; tm_pos = 0; tm_frame = '1;
        rm_mode = 0; rm_s = 0; n = 0; rm_bits = '0;
        ev_d1 = '0; ev_d2 = '0; e_stb = 0; e_err = 0; e_data = '0;
      end else begin
        n++;
        if (tm_active) begin
          tm_pos++;
          if (tm_pos == 80) tm_active = 0;
        end else if (cap_stb) begin
          tm_active = 1; tm_pos = 0; tm_frame = {1'b1, cap_data, 1'b0};
        end
        ev = '0;
        if (rm_mode == 0) begin
          if (!cap_line) begin rm_mode = 1; rm_s = n; end
        end else if (rm_mode == 1) begin
          rm_k = n - rm_s;
          if (rm_k == 4 && cap_line) rm_mode = 0;
          else if (rm_k >= 12 && rm_k <= 68 && rm_k % 8 == 4) rm_bits[(rm_k - 12) / 8] = cap_line;
          else if (rm_k == 76) begin
            ev = {cap_line, !cap_line, rm_bits};
            rm_mode = cap_line ? 0 : 2;
          end
        end else if (cap_line) rm_mode = 0;
        e_stb = ev_d2[9];
        e_err = ev_d2[8];
        if (ev_d2[9]) e_data = ev_d2[7:0];
        ev_d2 = ev_d1;
        ev_d1 = ev;
      end
      #1;
      exp_tx = tm_active ? tm_frame[tm_pos / 8] : 1'b1;
      chk("tx_line", o_uart_tx, exp_tx);
      chk("tx_busy", o_tx_busy, tm_active);
      chk("rx_stb", o_rx_stb, e_stb);
      chk("rx_frame_err", o_rx_frame_err, e_err);
      chk("rx_data", o_rx_data, e_data);
      if (o_rx_stb) begin stb_cnt++; rx_q.push_back(o_rx_data); end
      if (o_rx_frame_err) err_cnt++;
    end
  end

  task automatic tick(input int c);
    repeat (c) @(negedge i_clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin rx_drv = b[i]; tick(8); end
    rx_drv = stop;
    tick(8);
  endtask

  task automatic strobe(input logic [7:0] d);
    i_tx_data = d;
    i_tx_stb = 1'b1;
    tick(1);
    i_tx_stb = 1'b0;
  endtask

  initial begin
    int s0, e0, bsy, w;
    tick(3);
    chk("rst_tx", o_uart_tx, 1);
    chk("rst_busy", o_tx_busy, 0);
    chk("rst_stb", o_rx_stb, 0);
    chk("rst_ferr", o_rx_frame_err, 0);
    chk("rst_data", o_rx_data, 0);
    i_reset_n = 1'b1;
    tick(4);
    // 1: TX 0xA5
    strobe(8'hA5);
    bsy = 0;
    for (int i = 0; i < 80; i++) begin
      chk("t1_line", o_uart_tx, a5_line[i / 8]);
      if (o_tx_busy) bsy++;
      tick(1);
    end
    chk("t1_busy_cycles", bsy, 80);
    chk("t1_busy_end", o_tx_busy, 0);
    chk("t1_idle_line", o_uart_tx, 1);
    // 2: RX 0x3C
    tick(5);
    s0 = stb_cnt; e0 = err_cnt;
    send_rx(8'h3C, 1'b1);
    tick(20);
    chk("t2_stb_count", stb_cnt - s0, 1);
    chk("t2_ferr_count", err_cnt - e0, 0);
    chk("t2_data_held", o_rx_data, 8'h3C);
    // 3: glitch then 0x81
    s0 = stb_cnt; e0 = err_cnt;
    rx_drv = 1'b0;
    tick(2);
    rx_drv = 1'b1;
    tick(20);
    chk("t3_glitch_stb", stb_cnt - s0, 0);
    chk("t3_glitch_ferr", err_cnt - e0, 0);
    send_rx(8'h81, 1'b1);
    tick(20);
    chk("t3_stb_count", stb_cnt - s0, 1);
    chk("t3_data", o_rx_data, 8'h81);
    // 4: framing error, break, then 0x55
    s0 = stb_cnt; e0 = err_cnt;
    send_rx(8'hF0, 1'b0);
    rx_drv = 1'b0;
    tick(40);
    chk("t4_ferr_count", err_cnt - e0, 1);
    chk("t4_break_stb", stb_cnt - s0, 0);
    chk("t4_data_unchanged", o_rx_data, 8'h81);
    rx_drv = 1'b1;
    tick(16);
    send_rx(8'h55, 1'b1);
    tick(20);
    chk("t4_stb_count", stb_cnt - s0, 1);
    chk("t4_data", o_rx_data, 8'h55);
    chk("t4_ferr_total", err_cnt - e0, 1);
    // 5: loopback, strobe while busy is dropped, strobe on first idle cycle
    loop_en = 1'b1;
    tick(4);
    rx_q.delete();
    strobe(8'h12);
    tick(10);
    strobe(8'h34);
    w = 0;
    while (o_tx_busy && w < 200) begin tick(1); w++; end
    chk("t5_idle_reached", o_tx_busy, 0);
    strobe(8'h56);
    chk("t5_start_follows", o_uart_tx, 0);
    chk("t5_busy_again", o_tx_busy, 1);
    tick(100);
    chk("t5_rx_count", rx_q.size(), 2);
    chk("t5_rx_first", rx_q.size() > 0 ? rx_q[0] : 8'hEE, 8'h12);
    chk("t5_rx_second", rx_q.size() > 1 ? rx_q[1] : 8'hEE, 8'h56);
    loop_en = 1'b0;
    tick(4);
    // 6: asynchronous reset mid TX data bit and mid RX frame
    s0 = stb_cnt;
    rx_drv = 1'b0;
    strobe(8'h00);
    tick(30);
    chk("t6_tx_low_before", o_uart_tx, 0);
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("t6_tx_async", o_uart_tx, 1);
    chk("t6_busy_async", o_tx_busy, 0);
    rx_drv = 1'b1;
    tick(3);
    i_reset_n = 1'b1;
    tick(100);
    chk("t6_no_stb", stb_cnt - s0, 0);
    chk("t6_data_cleared", o_rx_data, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
